// File: rtl/matmult_pkg.sv
// Shared types and sizing helpers for the matrix-multiplier result collector.
package matmult_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    localparam int DEF_ELEMENTS_NUM = 4;
    localparam int DEF_DATA_WIDTH   = 4;
    localparam int FRAME_WORDS      = DEF_ELEMENTS_NUM * DEF_ELEMENTS_NUM;

    // Width of one product-sum: two operands multiplied, N terms accumulated, plus sign/guard bit.
    function automatic int res_width(input int data_width, input int elements_num);
        return data_width * 2 + $clog2(elements_num) + 1;
    endfunction

    function automatic int frame_words(input int elements_num);
        return elements_num * elements_num;
    endfunction

endpackage

// File: rtl/matmult_result_buf.sv
// Frame buffer: one write port, one registered read port, no reset on contents.
module matmult_result_buf #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 11,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write accepted result words.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; output holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/matmult_result_collector.sv
// Collects one N x N result frame from the multiplier stream, checks its
// length against the last flag and exposes it through a registered read port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | accepting words, ready_in high
//   DONE    | frame captured, upstream back-pressured, buffer readable
module matmult_result_collector
    import matmult_pkg::*;
#(
    parameter int  elementsNum = DEF_ELEMENTS_NUM,
    parameter int  dataWidth   = DEF_DATA_WIDTH,
    localparam int RES_W       = res_width(dataWidth, elementsNum),
    localparam int FRAME_W     = frame_words(elementsNum),
    localparam int ADDR_W      = $clog2(FRAME_W),
    localparam int CNT_W       = ADDR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [RES_W-1:0]  i_in,
    input  logic              i_valid_in,
    output logic              o_ready_in,
    input  logic              i_last_in,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [RES_W-1:0]  o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_release,
    output logic              o_done,
    output logic              o_err_short,
    output logic              o_err_no_last,
    output logic [CNT_W-1:0]  o_word_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_word_count;
    logic              r_err_short;
    logic              r_err_no_last;
    logic              r_rd_valid;
    logic              r_rd_zero;
    logic              w_xfer;
    logic              w_at_end;
    logic              w_frame_end;
    logic              w_rearm;
    logic              w_rd_req;
    logic              w_rd_in_range;
    logic [RES_W-1:0]  w_buf_q;

    assign o_ready_in    = (r_state == COLLECT) && !i_rst;
    assign w_xfer        = i_valid_in && o_ready_in;
    assign w_at_end      = (r_wr_ptr == ADDR_W'(FRAME_W - 1));
    assign w_frame_end   = w_xfer && (i_last_in || w_at_end);
    assign w_rearm       = (r_state == DONE) && i_release;
    assign w_rd_req      = i_rd_en && (r_state == DONE);
    assign w_rd_in_range = ({1'b0, i_rd_addr} < r_word_count);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_frame_end) w_state_next = DONE;
            DONE:    if (i_release)   w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    // Write pointer, word count and frame-length error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_rearm) begin
            r_wr_ptr      <= '0;
            r_word_count  <= '0;
            r_err_short   <= 1'b0;
            r_err_no_last <= 1'b0;
        end else if (w_xfer) begin
            r_word_count <= r_word_count + CNT_W'(1);
            // Pointer parks on the final word so it can never wrap onto address 0.
            if (!w_frame_end) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            r_err_short   <= i_last_in && !w_at_end;
            r_err_no_last <= !i_last_in && w_at_end;
        end
    end

    // Read handshake; out-of-range reads are forced to zero at the output mux.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_req;
            if (w_rd_req) begin
                r_rd_zero <= !w_rd_in_range;
            end
        end
    end

    matmult_result_buf #(
        .DEPTH (FRAME_W),
        .WIDTH (RES_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_xfer),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_in),
        .i_rd_en   (w_rd_req),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (w_buf_q)
    );

    assign o_rd_data     = r_rd_zero ? '0 : w_buf_q;
    assign o_rd_valid    = r_rd_valid;
    assign o_done        = (r_state == DONE);
    assign o_err_short   = r_err_short;
    assign o_err_no_last = r_err_no_last;
    assign o_word_count  = r_word_count;

endmodule
